// File: rtl/skid_register_pkg.sv
// Shared types and constants for the skid_register elastic stage.
package skid_register_pkg;

  // Control states: how many words the stage is holding.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Occupancy values reported on the count port.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Map a control state to the number of words held.
  function automatic logic [1:0] occupancy(input state_t s);
    logic [1:0] occ;
    occ = OCC_EMPTY;
    case (s)
      BUSY:    occ = OCC_BUSY;
      FULL:    occ = OCC_FULL;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/skid_register_register.sv
// Enabled data register with asynchronous clear, used for the main and
// skid word slots of skid_register.
module register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled; clear immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/skid_register.sv
// Elastic pipeline stage: one main word driving the output plus one skid
// word that absorbs the in-flight transfer when downstream stalls. in_ready
// is a flop, so no combinational path runs from out_ready to in_ready.
module skid_register
  import skid_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  state_t           state_reg;
  state_t           state_next;
  logic             in_ready_reg;
  logic             in_xfer;
  logic             out_xfer;
  logic             main_en;
  logic             skid_en;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign in_xfer  = in_valid & in_ready_reg;
  assign out_xfer = out_valid & out_ready;

  // Main slot: its output is the word presented downstream.
  register #(.WIDTH(WIDTH)) main_slot (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (out_data)
  );

  // Skid slot: only ever loaded from in_data while the main slot is stalled.
  register #(.WIDTH(WIDTH)) skid_slot (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (in_data),
    .q   (skid_q)
  );

  // Next-state and slot-enable decode from the two handshakes.
  always_comb begin
    state_next = state_reg;
    main_en    = 1'b0;
    skid_en    = 1'b0;
    main_d     = in_data;
    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          state_next = BUSY;
          main_en    = 1'b1;
        end
      end
      BUSY: begin
        case ({in_xfer, out_xfer})
          2'b10: begin
            state_next = FULL;
            skid_en    = 1'b1;
          end
          2'b01: begin
            state_next = EMPTY;
          end
          2'b11: begin
            main_en    = 1'b1;
          end
          default: begin
            state_next = BUSY;
          end
        endcase
      end
      FULL: begin
        // in_ready is low here, so only the drain side can move.
        if (out_xfer) begin
          state_next = BUSY;
          main_en    = 1'b1;
          main_d     = skid_q;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // State and registered in_ready; in_ready stays low until the first clean edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != FULL);
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != EMPTY);
  assign count     = occupancy(state_reg);

endmodule

// File: tb/tb_skid_register.sv
// Directed and random checks for skid_register with a queue scoreboard.
module tb_skid_register;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;

  int total = 0;
  int bad = 0;
  logic [WIDTH-1:0] sb[$];
  logic             armed = 1'b0;
  logic             hold_prev = 1'b0;
  logic [WIDTH-1:0] data_prev = '0;

  skid_register #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples pre-edge values, pops on out_xfer, pushes on in_xfer.
  always @(posedge clk) begin
    if (rst) begin
      armed     <= 1'b0;
      hold_prev <= 1'b0;
    end else begin
      if (armed) begin
        check("in_ready_vs_count", {31'd0, in_ready}, {31'd0, (count != 2'd2)});
        if (count == 2'd0) check("no_output_when_empty", {31'd0, out_valid}, 32'd0);
        if (hold_prev) begin
          check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
          check("stall_hold_data", {24'd0, out_data}, {24'd0, data_prev});
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out_xfer: got %0h expected no transfer at %0t", out_data, $time);
        end else begin
          check("out_xfer_data", {24'd0, out_data}, {24'd0, sb[0]});
          $display("xfer out data=%02h exp=%02h t=%0t", out_data, sb[0], $time);
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      hold_prev <= out_valid && !out_ready;
      data_prev <= out_data;
      armed     <= 1'b1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                            input logic [1:0] c, input logic r);
    check({tag, "_out_valid"}, {31'd0, out_valid}, {31'd0, v});
    if (v) check({tag, "_out_data"}, {24'd0, out_data}, {24'd0, d});
    check({tag, "_count"}, {30'd0, count}, {30'd0, c});
    check({tag, "_in_ready"}, {31'd0, in_ready}, {31'd0, r});
  endtask

  initial begin
    // 1. Reset held for five cycles.
    repeat (5) @(negedge clk);
    expect_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);
    check("reset_out_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    #1 check("rst_fall_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    expect_out("post_reset", 1'b0, 8'h00, 2'd0, 1'b1);

    // 6. Backpressure toggling on an empty stage.
    for (int i = 0; i < 8; i++) begin
      out_ready = i[0];
      @(negedge clk);
      expect_out("empty_toggle", 1'b0, 8'h00, 2'd0, 1'b1);
    end

    // 2. Streaming 1..100 with out_ready high.
    out_ready = 1'b1;
    for (int i = 1; i <= 101; i++) begin
      if (i > 1) expect_out("stream", 1'b1, 8'(i - 1), 2'd1, 1'b1);
      in_valid = (i <= 100);
      in_data  = 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    expect_out("stream_drained", 1'b0, 8'h00, 2'd0, 1'b1);

    // 3. Stall into skid: 0xA5 then 0x3C, garbage ignored while full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;
    @(negedge clk);
    expect_out("stall_first", 1'b1, 8'hA5, 2'd1, 1'b1);
    in_data = 8'h3C;
    @(negedge clk);
    expect_out("stall_full", 1'b1, 8'hA5, 2'd2, 1'b0);
    in_data = 8'hFF;
    @(negedge clk);
    expect_out("stall_ignore", 1'b1, 8'hA5, 2'd2, 1'b0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    expect_out("skid_drain1", 1'b1, 8'h3C, 2'd1, 1'b1);
    @(negedge clk);
    expect_out("skid_drain2", 1'b0, 8'h00, 2'd0, 1'b1);

    // 4. Simultaneous in/out transfer while BUSY.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    @(negedge clk);
    expect_out("simul_load", 1'b1, 8'h11, 2'd1, 1'b1);
    in_data   = 8'h22;
    out_ready = 1'b1;
    @(negedge clk);
    expect_out("simul_xfer", 1'b1, 8'h22, 2'd1, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    expect_out("simul_drain", 1'b0, 8'h00, 2'd0, 1'b1);

    // 1b. Asynchronous reset while FULL.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    @(negedge clk);
    in_data = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    expect_out("prefull", 1'b1, 8'h01, 2'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    expect_out("async_rst", 1'b0, 8'h00, 2'd0, 1'b0);
    check("async_rst_out_data", {24'd0, out_data}, 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    rst = 1'b0;
    #1 check("async_fall_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    expect_out("after_async", 1'b0, 8'h00, 2'd0, 1'b1);
    @(negedge clk);
    expect_out("no_stale", 1'b0, 8'h00, 2'd0, 1'b1);

    // 5. Random stress; the monitor checks ordering and invariants.
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_data   = 8'($urandom);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    expect_out("final", 1'b0, 8'h00, 2'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/skid_register.md
Name: skid_register

Overview:
- Elastic pipeline stage with valid/ready handshake on both sides.
- Full throughput (1 word/cycle) and 1-cycle latency. Registered in_ready, so ready timing is cut between stages.
- Sits directly downstream of a producer and upstream of a consumer in datapath pipelines.
- Stores words in enabled `register` instances, plus a small control FSM.

Parameters:
- WIDTH, 8, data width in bits.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- in_valid, input, 1, upstream word present.
- in_ready, output, 1, stage can accept; registered.
- in_data, input, WIDTH, upstream word.
- out_valid, output, 1, out_data holds a valid word.
- out_ready, input, 1, downstream accepts.
- out_data, output, WIDTH, word presented downstream.
- count, output, 2, occupancy 0..2.

Interface (already decided):
- One clock, clk.
- Reset rst is asynchronous and active-high.

Behaviour:
- Transfer definitions: in_xfer = in_valid & in_ready. out_xfer = out_valid & out_ready.
- Storage: main register drives out_data; skid register catches one word when downstream stalls.
- FSM states: EMPTY (0 words), BUSY (main valid), FULL (main + skid valid).
- EMPTY: in_xfer -> BUSY, main <= in_data.
- BUSY:
  - in_xfer & !out_xfer -> FULL, skid <= in_data.
  - !in_xfer & out_xfer -> EMPTY.
  - in_xfer & out_xfer -> BUSY, main <= in_data.
  - neither -> hold.
- FULL:
  - out_xfer -> BUSY, main <= skid.
  - else hold.
  - in_ready = 0, so no in_xfer is possible.
- in_ready: registered; next value = (next_state != FULL).
- out_valid = (state != EMPTY); count = 0/1/2 for EMPTY/BUSY/FULL.
- Latency: a word accepted at edge N is on out_data/out_valid after edge N. Sustained throughput is 1 word/cycle when out_ready = 1.
- Ordering: strict FIFO; words are never dropped or duplicated.
- Stability: while out_valid & !out_ready, out_data and out_valid hold their values.
- in_valid while in_ready = 0 is ignored; upstream must hold it.
- Reset (async, immediate on rst rise, no clock needed):
  - state = EMPTY, out_valid = 0, in_ready = 0, count = 0, out_data = '0, skid = '0.
  - in_ready rises on the first clk edge with rst = 0.
- Reset mid-operation: contents are discarded; no stale word appears after rst falls.
- Upstream is not required to keep in_data stable when in_ready = 0; it is captured only on in_xfer.

Decomposition:
- Package skid_register_pkg:
  - typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t.
  - Occupancy constants.
- Sub-module: instantiate the existing `register` (WIDTH, en) twice, for main and skid storage, with enables driven by the FSM.
- One FSM block plus next-state logic in skid_register.

Test Plan:
1. Reset check:
   - Stimulus: rst = 1 for 5 cycles, then asynchronous rst pulse mid-FULL.
   - Response: within 1 ns of rst rise, out_valid = 0, in_ready = 0, count = 0, out_data = 0; in_ready = 1 one edge after rst falls.
2. Streaming:
   - Stimulus: out_ready = 1, in_valid = 1, in_data = 1,2,3,...,100 on consecutive cycles.
   - Response: out_data = 1..100 on consecutive cycles, each one cycle after its in_xfer; count stays 1; in_ready stays 1.
3. Stall into skid:
   - Stimulus: send 0xA5 then 0x3C with out_ready = 0.
   - Response: count = 2, in_ready = 0 after 2nd edge, out_data = 0xA5 held. Then out_ready = 1 yields 0xA5 then 0x3C; in_ready returns to 1 one edge after the first out_xfer.
4. Simultaneous transfers:
   - Stimulus: BUSY with 0x11, then in_data = 0x22 with in_valid = out_ready = 1.
   - Response: state BUSY, out_data = 0x22 next cycle, count = 1.
5. Random stress:
   - Stimulus: 10000 cycles, random in_valid/out_ready/in_data, queue scoreboard.
   - Response, checked by assertions:
     - every out_xfer matches the queue head;
     - out_data stable while out_valid & !out_ready;
     - in_ready == (count != 2), delayed one cycle;
     - no output while count == 0.
6. Backpressure on empty:
   - Stimulus: in_valid = 0, out_ready toggling.
   - Response: out_valid stays 0, count = 0, no spurious transfer.
